// File: rtl/dispense_pkg.sv
// Shared types and default sizing for the cola dispense sequencer.
package dispense_pkg;
  localparam int unsigned DEPTH_DEF   = 4;
  localparam int unsigned TIMEOUT_DEF = 16;
  localparam int unsigned CNT_W       = 3;

  typedef enum logic [1:0] {
    IDLE,
    MOTOR,
    HOPPER,
    FAULT
  } state_t;
endpackage

// File: rtl/dispense_sequencer_if.sv
// Coin-engine / actuator signal bundle around the dispense sequencer.
interface dispense_sequencer_if;
  import dispense_pkg::*;

  logic             open_req;
  logic             change_req;
  logic             motor_done;
  logic             hopper_done;
  logic             clear_fault;
  logic             motor_en;
  logic             hopper_en;
  logic             busy;
  logic             fault;
  logic [CNT_W-1:0] pending_cnt;
  logic             drop_err;

  modport master (
    output open_req, change_req, motor_done, hopper_done, clear_fault,
    input  motor_en, hopper_en, busy, fault, pending_cnt, drop_err
  );

  modport slave (
    input  open_req, change_req, motor_done, hopper_done, clear_fault,
    output motor_en, hopper_en, busy, fault, pending_cnt, drop_err
  );
endinterface

// File: rtl/dispense_sequencer_req_fifo.sv
// Pending-vend queue: DEPTH one-bit entries (change owed), head at bit 0.
module req_fifo
  import dispense_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic             din,
  output logic             dout,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  logic [DEPTH-1:0] mem, mem_n;
  logic [CNT_W-1:0] count_n, widx;
  logic             push_ok, pop_ok;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[0];

  // Shift-down on pop, so a simultaneous push lands one slot lower.
  always_comb begin
    mem_n = mem;
    widx  = count;
    if (pop_ok) begin
      mem_n = mem >> 1;
      widx  = count - 1'b1;
    end
    if (push_ok) begin
      mem_n = (mem_n & ~(DEPTH'(1) << widx)) | (DEPTH'(din) << widx);
    end
    count_n = count + CNT_W'(push_ok) - CNT_W'(pop_ok);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
      mem   <= '0;
    end else if (flush) begin
      count <= '0;
      mem   <= '0;
    end else begin
      count <= count_n;
      mem   <= mem_n;
    end
  end
endmodule

// File: rtl/dispense_sequencer.sv
// Cola vend sequencer: queues vend requests, runs motor then optional change
// hopper per job, with per-actuator timeout into a latched fault state.
module dispense_sequencer
  import dispense_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  dispense_sequencer_if.slave  bus
);
  localparam int unsigned      TMR_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMR_W-1:0] TMR_TOP = TMR_W'(TIMEOUT - 1);

  state_t           state, state_n;
  logic [TMR_W-1:0] timer;
  logic             change_flag;
  logic             motor_en_q, hopper_en_q, drop_q;
  logic             push, pop, flush, drop;
  logic             q_dout, q_full, q_empty;
  logic [CNT_W-1:0] q_count;

  req_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .din   (bus.change_req),
    .dout  (q_dout),
    .full  (q_full),
    .empty (q_empty),
    .count (q_count)
  );

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    flush   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!q_empty) begin
          pop     = 1'b1;
          state_n = MOTOR;
        end
      end
      MOTOR: begin
        if (bus.motor_done) begin
          state_n = change_flag ? HOPPER : IDLE;
        end else if (timer == TMR_TOP) begin
          state_n = FAULT;
          flush   = 1'b1;
        end
      end
      HOPPER: begin
        if (bus.hopper_done) begin
          state_n = IDLE;
        end else if (timer == TMR_TOP) begin
          state_n = FAULT;
          flush   = 1'b1;
        end
      end
      FAULT: begin
        if (bus.clear_fault) begin
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    // Fullness is judged on the pre-pop count: no pass-through on a full queue.
    push = bus.open_req && (state != FAULT);
    drop = bus.open_req && (q_full || (state == FAULT));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      timer       <= '0;
      change_flag <= 1'b0;
      motor_en_q  <= 1'b0;
      hopper_en_q <= 1'b0;
      drop_q      <= 1'b0;
    end else begin
      state <= state_n;
      if (state_n != state) begin
        timer <= '0;
      end else if ((state == MOTOR) || (state == HOPPER)) begin
        timer <= timer + 1'b1;
      end
      if (pop) begin
        change_flag <= q_dout;
      end
      motor_en_q  <= (state_n == MOTOR);
      hopper_en_q <= (state_n == HOPPER);
      drop_q      <= drop;
    end
  end

  assign bus.motor_en    = motor_en_q;
  assign bus.hopper_en   = hopper_en_q;
  assign bus.busy        = (state != IDLE);
  assign bus.fault       = (state == FAULT);
  assign bus.pending_cnt = q_count;
  assign bus.drop_err    = drop_q;
endmodule

// File: tb/tb_dispense_sequencer.sv
// Bench for dispense_sequencer: directed scenarios with literal expectations,
// then random traffic checked every cycle against a queue-based job model.
module tb_dispense_sequencer;
  localparam int unsigned DEPTH   = 4;
  localparam int unsigned TIMEOUT = 16;

  typedef enum int {P_IDLE, P_MOTOR, P_HOPPER, P_FAULT} phase_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   tests = 0;
  int   fails = 0;
  bit   chk_en = 1'b0;

  dispense_sequencer_if bus ();

  dispense_sequencer #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model: jobs are bits in a queue; an active job spends counted
  // cycles on its actuator and faults after TIMEOUT of them without done.
  bit     mq[$];
  phase_t ph = P_IDLE;
  int     spent = 0;
  bit     cur_flag = 1'b0;
  bit     m_drop = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      mq.delete();
      ph       = P_IDLE;
      spent    = 0;
      cur_flag = 1'b0;
      m_drop   = 1'b0;
    end else begin
      bit     was_full, was_fault;
      phase_t nxt;
      was_full  = (mq.size() == DEPTH);
      was_fault = (ph == P_FAULT);
      nxt       = ph;
      case (ph)
        P_IDLE:   if (mq.size() != 0) begin cur_flag = mq.pop_front(); nxt = P_MOTOR; end
        P_MOTOR: begin
          spent++;
          if (bus.motor_done) nxt = cur_flag ? P_HOPPER : P_IDLE;
          else if (spent == TIMEOUT) nxt = P_FAULT;
        end
        P_HOPPER: begin
          spent++;
          if (bus.hopper_done) nxt = P_IDLE;
          else if (spent == TIMEOUT) nxt = P_FAULT;
        end
        default:  if (bus.clear_fault) nxt = P_IDLE;
      endcase
      if (nxt != ph) spent = 0;
      m_drop = bus.open_req && (was_full || was_fault);
      if (bus.open_req && !was_full && !was_fault) mq.push_back(bus.change_req);
      if (nxt == P_FAULT && ph != P_FAULT) mq.delete();
      ph = nxt;
    end
  end

  task automatic chk1(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk1("m_motor_en",  bus.motor_en,  ph == P_MOTOR);
      chk1("m_hopper_en", bus.hopper_en, ph == P_HOPPER);
      chk1("m_busy",      bus.busy,      ph != P_IDLE);
      chk1("m_fault",     bus.fault,     ph == P_FAULT);
      chk8("m_pending",   8'(bus.pending_cnt), 8'(mq.size()));
      chk1("m_drop_err",  bus.drop_err,  m_drop);
    end
  end

  task automatic tick(input bit o, input bit c, input bit md, input bit hd, input bit cf);
    @(negedge clk);
    #1;
    bus.open_req    = o;
    bus.change_req  = c;
    bus.motor_done  = md;
    bus.hopper_done = hd;
    bus.clear_fault = cf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_ticks(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    bit flags [4];
    flags = '{1'b1, 1'b0, 1'b1, 1'b1};
    bus.open_req = 0; bus.change_req = 0; bus.motor_done = 0;
    bus.hopper_done = 0; bus.clear_fault = 0;
    @(posedge clk);
    #2;
    reset = 1'b0;
    chk_en = 1'b1;
    chk1("rst_motor_en", bus.motor_en, 1'b0);
    chk1("rst_hopper_en", bus.hopper_en, 1'b0);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_fault", bus.fault, 1'b0);
    chk8("rst_pending", 8'(bus.pending_cnt), 8'd0);
    chk1("rst_drop_err", bus.drop_err, 1'b0);

    // Single vend, no change.
    tick(1, 0, 0, 0, 0);
    chk8("v1_pending_n", 8'(bus.pending_cnt), 8'd1);
    chk1("v1_motor_n", bus.motor_en, 1'b0);
    tick(0, 0, 0, 0, 0);
    chk1("v1_motor_n1", bus.motor_en, 1'b1);
    chk8("v1_pending_n1", 8'(bus.pending_cnt), 8'd0);
    idle_ticks(2);
    chk1("v1_motor_e4", bus.motor_en, 1'b1);
    tick(0, 0, 1, 0, 0);
    chk1("v1_motor_off", bus.motor_en, 1'b0);
    chk1("v1_hopper", bus.hopper_en, 1'b0);
    chk1("v1_busy", bus.busy, 1'b0);

    // Vend with change.
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    chk1("v2_motor", bus.motor_en, 1'b1);
    idle_ticks(2);
    tick(0, 0, 1, 0, 0);
    chk1("v2_hopper_on", bus.hopper_en, 1'b1);
    chk1("v2_motor_off", bus.motor_en, 1'b0);
    tick(0, 0, 0, 0, 0);
    tick(0, 0, 0, 1, 0);
    chk1("v2_hopper_off", bus.hopper_en, 1'b0);
    chk1("v2_busy", bus.busy, 1'b0);

    // Overflow while one job is already on the motor.
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) tick(1, flags[i], 0, 0, 0);
    chk8("ovf_peak", 8'(bus.pending_cnt), 8'd4);
    chk1("ovf_no_drop_yet", bus.drop_err, 1'b0);
    tick(1, 0, 0, 0, 0);
    chk1("ovf_drop", bus.drop_err, 1'b1);
    chk8("ovf_still4", 8'(bus.pending_cnt), 8'd4);
    tick(0, 0, 0, 0, 0);
    chk1("ovf_drop_pulse", bus.drop_err, 1'b0);
    tick(0, 0, 1, 0, 0);
    chk1("ovf_job0_idle", bus.busy, 1'b0);
    for (int i = 0; i < 4; i++) begin
      tick(0, 0, 0, 0, 0);
      chk1("ovf_dwell_motor", bus.motor_en, 1'b1);
      chk8("ovf_pending", 8'(bus.pending_cnt), 8'(3 - i));
      tick(0, 0, 1, 0, 0);
      chk1("ovf_flag_order", bus.hopper_en, flags[i]);
      if (flags[i]) tick(0, 0, 0, 1, 0);
    end
    chk1("ovf_done_busy", bus.busy, 1'b0);

    // Motor timeout into fault, with one vend queued behind it.
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    chk8("to_queued", 8'(bus.pending_cnt), 8'd1);
    idle_ticks(14);
    chk1("to_motor_cyc15", bus.motor_en, 1'b1);
    chk1("to_nofault_yet", bus.fault, 1'b0);
    tick(0, 0, 0, 0, 0);
    chk1("to_fault", bus.fault, 1'b1);
    chk1("to_motor_off", bus.motor_en, 1'b0);
    chk8("to_flushed", 8'(bus.pending_cnt), 8'd0);
    tick(1, 0, 0, 0, 0);
    chk1("to_fault_drop", bus.drop_err, 1'b1);
    chk8("to_fault_nopush", 8'(bus.pending_cnt), 8'd0);
    tick(0, 0, 0, 0, 1);
    chk1("to_cleared", bus.fault, 1'b0);
    chk1("to_cleared_busy", bus.busy, 1'b0);

    // Done on the final allowed motor cycle beats the timeout.
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    idle_ticks(15);
    tick(0, 0, 1, 0, 0);
    chk1("col_nofault", bus.fault, 1'b0);
    chk1("col_idle", bus.busy, 1'b0);

    // Asynchronous reset while the hopper runs with two vends queued.
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 0, 0, 0);
    tick(1, 0, 0, 0, 0);
    tick(1, 1, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    chk1("rm_hopper", bus.hopper_en, 1'b1);
    chk8("rm_pending2", 8'(bus.pending_cnt), 8'd2);
    #2;
    reset = 1'b1;
    #1;
    chk1("rm_hopper_off", bus.hopper_en, 1'b0);
    chk1("rm_busy", bus.busy, 1'b0);
    chk8("rm_pending0", 8'(bus.pending_cnt), 8'd0);
    @(negedge clk);
    #1;
    reset = 1'b0;
    tick(1, 0, 0, 0, 0);
    chk8("rm_first_after", 8'(bus.pending_cnt), 8'd1);

    // Random traffic, with rare asynchronous reset pulses between edges.
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        #1;
        reset = 1'b1;
        #2;
        reset = 1'b0;
      end
      tick($urandom_range(0, 9) < 4, $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, $urandom_range(0, 3) == 0,
           $urandom_range(0, 2) == 0);
    end
    idle_ticks(2);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
